// File: rtl/unary_pkg.sv
// Shared types and sizing helpers for the unary
// operand encoder feeding the unary adder.
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DRAIN
  } enc_state_t;

  function automatic int win_width(
    input int u_bits,
    input int guard
  );
    return $clog2(2 * u_bits + guard + 1);
  endfunction

endpackage

// File: rtl/unary_emitter.sv
// Loadable down-counter; the stream is high while
// the count is nonzero, giving one contiguous pulse.
module unary_emitter #(
  parameter int BIN_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  output logic             stream,
  output logic             next_zero
);

  logic [BIN_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign stream    = (cnt != '0);
  // count will be zero after this cycle's decrement
  assign next_zero = (cnt <= BIN_W'(1));

endmodule

// File: rtl/unary_pair_encoder.sv
// Binary pair to aligned unary streams, holding off
// new pairs until the downstream sum window closes.
module unary_pair_encoder
  import unary_pkg::*;
#(
  parameter int U_BITS       = 16,
  parameter int GUARD_CYCLES = 1,
  parameter int BIN_W        = $clog2(U_BITS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] a_bin,
  input  logic [BIN_W-1:0] b_bin,
  output logic             a_unary,
  output logic             b_unary,
  output logic             busy,
  output logic             done
);

  localparam int WIN_W = win_width(U_BITS, GUARD_CYCLES);
  localparam logic [BIN_W-1:0] U_MAX = BIN_W'(U_BITS);
  localparam logic [WIN_W-1:0] W_ONE = WIN_W'(1);

  enc_state_t       state;
  enc_state_t       state_nx;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] win_load;
  logic [BIN_W-1:0] a_sat;
  logic [BIN_W-1:0] b_sat;
  logic             xfer;
  logic             a_last;
  logic             b_last;
  logic             win_last;

  assign xfer  = in_valid && in_ready;

  // clamp keeps the adder LIFO from overflowing
  assign a_sat = (a_bin > U_MAX) ? U_MAX : a_bin;
  assign b_sat = (b_bin > U_MAX) ? U_MAX : b_bin;

  assign win_load = WIN_W'(a_sat) + WIN_W'(b_sat)
                  + WIN_W'(GUARD_CYCLES);

  assign win_last = (win == W_ONE);

  unary_emitter #(
    .BIN_W (BIN_W)
  ) u_emit_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (xfer),
    .value     (a_sat),
    .stream    (a_unary),
    .next_zero (a_last)
  );

  unary_emitter #(
    .BIN_W (BIN_W)
  ) u_emit_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (xfer),
    .value     (b_sat),
    .stream    (b_unary),
    .next_zero (b_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      win   <= '0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        win <= win_load;
      end else if (win != '0) begin
        win <= win - 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = EMIT;
        end
      end
      EMIT: begin
        busy = 1'b1;
        done = win_last;
        if (win_last) begin
          state_nx = IDLE;
        end else if (a_last && b_last) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        done = win_last;
        if (win_last) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_unary_pair_encoder.sv
// Directed plus random stimulus against a cycle-count
// model of the unary pair encoder.
module tb_unary_pair_encoder;

  localparam int U  = 16;
  localparam int BW = 5;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] a_bin    = '0;
  logic [BW-1:0] b_bin    = '0;
  logic          in_ready;
  logic          a_unary;
  logic          b_unary;
  logic          busy;
  logic          done;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  bit active = 0;
  int k      = 0;
  int len    = 0;
  int ea     = 0;
  int eb     = 0;
  int acc    = 0;

  always #5 clk = ~clk;

  unary_pair_encoder #(
    .U_BITS       (U),
    .GUARD_CYCLES (1),
    .BIN_W        (BW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_bin    (a_bin),
    .b_bin    (b_bin),
    .a_unary  (a_unary),
    .b_unary  (b_unary),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // one clock: model decides transfer from inputs,
  // then every output is compared after the edge
  task automatic tick();
    bit xf;
    int sa;
    int sb;
    xf = reset_n && in_valid && !active;
    sa = (int'(a_bin) > U) ? U : int'(a_bin);
    sb = (int'(b_bin) > U) ? U : int'(b_bin);
    @(posedge clk);
    if (!reset_n) begin
      active = 0;
    end else if (xf) begin
      active = 1;
      k      = 0;
      ea     = sa;
      eb     = sb;
      len    = sa + sb + 1;
      acc    = 0;
    end
    #1;
    if (active) begin
      k++;
      if (k > len) active = 0;
    end
    chk("in_ready", 32'(in_ready), 32'(!active));
    chk("busy", 32'(busy), 32'(active));
    chk("a_unary", 32'(a_unary),
        32'(active && k <= ea));
    chk("b_unary", 32'(b_unary),
        32'(active && k <= eb));
    chk("done", 32'(done),
        32'(active && k == len));
    if (active) acc += int'(a_unary) + int'(b_unary);
    if (active && k == len) chk("stream_sum", acc, ea + eb);
  endtask

  task automatic send(input int a, input int b);
    in_valid = 1'b1;
    a_bin    = BW'(a);
    b_bin    = BW'(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    run(3);

    send(3, 5);
    run(12);

    send(0, 0);
    run(3);

    send(20, 16);
    run(36);

    send(3, 5);
    in_valid = 1'b1;
    a_bin    = BW'(9);
    b_bin    = BW'(2);
    run(9);
    a_bin    = BW'(7);
    b_bin    = BW'(4);
    run(2);
    in_valid = 1'b0;
    run(14);

    send(10, 4);
    run(1);
    reset_n = 1'b0;
    run(1);
    reset_n = 1'b1;
    run(4);

    send(0, 6);
    run(9);
    send(17, 0);
    run(19);

    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      a_bin    = BW'($urandom_range(0, 31));
      b_bin    = BW'($urandom_range(0, 31));
      reset_n  = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset_n  = 1'b1;
    in_valid = 1'b0;
    run(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
